pipeline_exec_controller: RTL and testbench
===========================================

Name: pipeline_exec_controller

Overview:
- Sequences execution of the 5-stage MIPS pipeline under debug-host control, supporting continuous run, single-step, break, and flush.
- Gates the global pipeline enable and the PC/fetch enable.
- Detects the HALT instruction and drains in-flight instructions before reporting completion.
- Sits between the debug command interface and the pipeline-stage registers and PC, alongside the control unit and hazard unit.

Parameters:
PIPE_DEPTH, 5, number of pipeline stages; drain length is PIPE_DEPTH-1 cycles.
CNT_W, 32, width of the executed-cycle counter.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_cmd_valid  in  1  command strobe from the debug interface.
i_cmd  in  2  command code: 00 BREAK, 01 RUN, 10 STEP, 11 FLUSH.
o_cmd_ready  out  1  controller accepts a command this cycle.
i_halt_fetched  in  1  HALT opcode present in the IF/ID register.
i_stall_hazard  in  1  load-use stall request from the hazard unit.
o_pipe_en  out  1  enable for all pipeline-stage registers.
o_pc_en  out  1  enable for the PC register / fetch.
o_pipe_flush  out  1  synchronous clear of pipeline registers and PC.
o_busy  out  1  high in RUN, STEP, DRAIN.
o_halted  out  1  sticky; program reached HALT or BREAK completed.
o_done  out  1  one-cycle pulse when a RUN/BREAK drain completes.
o_step_done  out  1  one-cycle pulse after a STEP cycle.
o_cycle_count  out  CNT_W  number of cycles with o_pipe_en=1 since the last reset or flush.
o_state  out  3  current state encoding, for debug readback.

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4, FLUSH=5.
- Reset (async, any state): state IDLE; o_halted=0; o_cycle_count=0; drain counter=0; o_done=0; o_step_done=0; o_pipe_flush=0.
- Command acceptance: a command is accepted on the rising edge where i_cmd_valid & o_cmd_ready. The state changes on that edge, so the effect is visible the following cycle.
- o_cmd_ready=1 in IDLE and RUN, 0 elsewhere.
- IDLE:
  - RUN: to RUN if o_halted=0; if o_halted=1, accepted and ignored.
  - STEP: to STEP if o_halted=0; if o_halted=1, accepted and ignored.
  - FLUSH: to FLUSH.
  - BREAK: no-op.
- RUN: commands other than BREAK are accepted and discarded.
  - o_pipe_en=1.
  - o_pc_en = ~i_stall_hazard & ~i_halt_fetched (combinational).
  - If i_halt_fetched=1, or an accepted BREAK occurs: to DRAIN with drain counter loaded to PIPE_DEPTH-1.
  - If HALT and BREAK occur in the same cycle, the behaviour is a single DRAIN.
- STEP: exactly one cycle.
  - o_pipe_en=1; o_pc_en as in RUN.
  - Next state: DRAIN if i_halt_fetched, else IDLE.
  - o_step_done pulses (registered) in the cycle after STEP in both cases.
- DRAIN:
  - o_pipe_en=1, o_pc_en=0; the counter decrements each cycle.
  - Leaves when counter==1, for exactly PIPE_DEPTH-1 DRAIN cycles, then to DONE.
  - i_halt_fetched and i_stall_hazard are ignored.
- DONE: one cycle.
  - o_pipe_en=0; o_done=1; o_halted set to 1.
  - Next state: IDLE.
- FLUSH: one cycle.
  - o_pipe_flush=1; o_pipe_en=0.
  - o_cycle_count cleared and o_halted cleared at the end of the cycle.
  - Next state: IDLE.
- o_pipe_en and o_pc_en are 0 in IDLE, DONE, FLUSH.
- o_busy = state in {RUN, STEP, DRAIN}.
- Cycle counter: increments on every edge where o_pipe_en=1. It saturates at all-ones (no wrap) and is held otherwise.
- Stall handling: a hazard stall in RUN/STEP still counts as a cycle. Only the PC is frozen; the hazard unit handles bubble insertion.

Test Plan:
- Reset, FLUSH, RUN; assert i_halt_fetched in the 10th RUN cycle -> 10 RUN cycles with o_pc_en=1 except the HALT cycle, 4 DRAIN cycles with o_pc_en=0, o_done pulse in the DONE cycle, o_halted=1, o_cycle_count=14.
- From IDLE, three STEP commands spaced 3 cycles apart -> three o_pipe_en single-cycle pulses, three o_step_done pulses one cycle later each, o_cycle_count=3.
- RUN, then BREAK accepted in RUN cycle 6 -> 4 DRAIN cycles, o_done, o_cycle_count=10, o_halted=1.
- While o_halted=1, issue RUN and STEP -> both accepted, state stays IDLE, o_pipe_en stays 0. Then FLUSH -> o_pipe_flush=1 for one cycle, o_cycle_count=0, o_halted=0; a subsequent RUN enters RUN.
- In RUN, hold i_stall_hazard for 2 cycles -> o_pc_en=0 and o_pipe_en=1 during those cycles, counter still increments by 2.
- Assert i_rst asynchronously mid-DRAIN (between edges) -> o_state=0, o_pipe_en=0, o_cycle_count=0 immediately, with no o_done pulse.

Source files
------------

// File: rtl/pipeline_exec_controller.sv
// Debug-host execution sequencer for the 5-stage pipeline: RUN / STEP / BREAK / FLUSH,
// HALT detection with a PIPE_DEPTH-1 cycle drain, and a saturating executed-cycle counter.
module pipeline_exec_controller #(
  parameter int PIPE_DEPTH = 5,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_fetched,
  input  logic             i_stall_hazard,
  output logic             o_pipe_en,
  output logic             o_pc_en,
  output logic             o_pipe_flush,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic             o_step_done,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [2:0]       o_state
);

  localparam int DW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;

  localparam logic [1:0] CMD_BREAK = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          cmd_acc;
  logic          exec_state;

  assign exec_state  = (state == S_RUN) || (state == S_STEP);
  assign o_cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign cmd_acc     = i_cmd_valid & o_cmd_ready;
  assign o_pipe_en   = exec_state || (state == S_DRAIN);
  assign o_busy      = o_pipe_en;
  // A fetched HALT must not advance the PC past itself; stalls only freeze the PC.
  assign o_pc_en     = exec_state & ~i_stall_hazard & ~i_halt_fetched;
  assign o_state     = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      drain_cnt     <= '0;
      o_halted      <= 1'b0;
      o_done        <= 1'b0;
      o_step_done   <= 1'b0;
      o_pipe_flush  <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_done       <= 1'b0;
      o_step_done  <= 1'b0;
      o_pipe_flush <= 1'b0;

      if (o_pipe_en && (o_cycle_count != {CNT_W{1'b1}}))
        o_cycle_count <= o_cycle_count + 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_acc) begin
            case (i_cmd)
              CMD_RUN:   if (!o_halted) state <= S_RUN;
              CMD_STEP:  if (!o_halted) state <= S_STEP;
              CMD_FLUSH: begin
                state        <= S_FLUSH;
                o_pipe_flush <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // HALT and BREAK together collapse into one drain.
          if (i_halt_fetched || (cmd_acc && (i_cmd == CMD_BREAK))) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(PIPE_DEPTH - 1);
          end
        end
        S_STEP: begin
          o_step_done <= 1'b1;
          if (i_halt_fetched) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(PIPE_DEPTH - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DW'(1)) begin
            state    <= S_DONE;
            o_done   <= 1'b1;
            o_halted <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FLUSH: begin
          o_cycle_count <= '0;
          o_halted      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Bench for pipeline_exec_controller: directed scenarios plus randomized episodes
// checked against a transaction-level model of cycle count and halted status.
module tb_pipeline_exec_controller;

  localparam int PD = 5;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [1:0] C_BREAK = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_FLUSH = 2'b11;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic [1:0]    i_cmd;
  logic          o_cmd_ready;
  logic          i_halt_fetched;
  logic          i_stall_hazard;
  logic          o_pipe_en;
  logic          o_pc_en;
  logic          o_pipe_flush;
  logic          o_busy;
  logic          o_halted;
  logic          o_done;
  logic          o_step_done;
  logic [CW-1:0] o_cycle_count;
  logic [2:0]    o_state;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  bit exp_halted = 0;

  pipeline_exec_controller #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt_fetched(i_halt_fetched),
    .i_stall_hazard(i_stall_hazard), .o_pipe_en(o_pipe_en), .o_pc_en(o_pc_en),
    .o_pipe_flush(o_pipe_flush), .o_busy(o_busy), .o_halted(o_halted),
    .o_done(o_done), .o_step_done(o_step_done), .o_cycle_count(o_cycle_count),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic do_flush();
    send(C_FLUSH);
    tick();
    exp_count = 0;
    exp_halted = 0;
  endtask

  // Counts DRAIN cycles until the DONE cycle (bounded), checks drain length and the done pulse, steps into IDLE.
  task automatic finish_drain(input string nm);
    int n = 0;
    int guard = 0;
    while (o_done !== 1'b1 && guard < 4 * PD) begin
      if (o_state == 3'd3) begin
        n++;
        checks++;
        if ({o_pipe_en, o_pc_en, o_busy} !== 3'b101) begin
          failures++;
          $display("FAIL %s drain_outputs got=%b exp=101", nm, {o_pipe_en, o_pc_en, o_busy});
        end
      end
      tick();
      guard++;
    end
    checks++;
    if (guard >= 4 * PD || n != PD - 1 || o_state !== 3'd4 || o_pipe_en !== 1'b0) begin
      failures++;
      $display("FAIL %s drain_len got=%0d state=%0d exp=%0d state=4", nm, n, o_state, PD - 1);
    end
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00;
    i_halt_fetched = 1'b0; i_stall_hazard = 1'b0;
    #12;
    checks++;
    if ({o_state, o_pipe_en, o_pc_en, o_pipe_flush, o_halted, o_done, o_step_done, o_busy, o_cmd_ready} !== {3'd0, 8'b00000001}
        || o_cycle_count !== '0) begin
      failures++;
      $display("FAIL reset_state got state=%0d cnt=%0d flags=%b", o_state, o_cycle_count,
               {o_pipe_en, o_pc_en, o_pipe_flush, o_halted, o_done, o_step_done, o_busy, o_cmd_ready});
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_run_halt();
    send(C_FLUSH);
    checks++;
    if ({o_state, o_pipe_flush, o_pipe_en, o_cmd_ready} !== {3'd5, 3'b100}) begin
      failures++;
      $display("FAIL flush_cycle got state=%0d flush=%b pe=%b rdy=%b exp 5/1/0/0", o_state, o_pipe_flush, o_pipe_en, o_cmd_ready);
    end
    tick();
    send(C_RUN);
    for (int k = 1; k <= 10; k++) begin
      i_halt_fetched = (k == 10);
      #1;
      checks++;
      if ({o_state, o_pipe_en, o_pc_en, o_busy} !== {3'd1, 1'b1, (k != 10), 1'b1}) begin
        failures++;
        $display("FAIL run_cycle%0d got state=%0d pe=%b pc=%b", k, o_state, o_pipe_en, o_pc_en);
      end
      tick();
    end
    finish_drain("run_halt");
    i_halt_fetched = 1'b0;
    checks++;
    if (o_cycle_count !== CW'(14) || o_halted !== 1'b1 || o_state !== 3'd0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL run_halt_end got cnt=%0d halted=%b state=%0d exp cnt=14 halted=1 state=0", o_cycle_count, o_halted, o_state);
    end
  endtask

  task automatic test_halted_ignore_flush();
    send(C_RUN);
    checks++;
    if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin
      failures++;
      $display("FAIL halted_run_ignored got state=%0d pe=%b exp 0/0", o_state, o_pipe_en);
    end
    send(C_STEP);
    tick();
    checks++;
    if (o_state !== 3'd0 || o_pipe_en !== 1'b0 || o_step_done !== 1'b0 || o_cycle_count !== CW'(14)) begin
      failures++;
      $display("FAIL halted_step_ignored got state=%0d pe=%b sd=%b cnt=%0d", o_state, o_pipe_en, o_step_done, o_cycle_count);
    end
    send(C_FLUSH);
    checks++;
    if (o_pipe_flush !== 1'b1 || o_halted !== 1'b1) begin
      failures++;
      $display("FAIL flush_during got flush=%b halted=%b exp 1/1", o_pipe_flush, o_halted);
    end
    tick();
    checks++;
    if (o_pipe_flush !== 1'b0 || o_halted !== 1'b0 || o_cycle_count !== '0 || o_state !== 3'd0) begin
      failures++;
      $display("FAIL flush_after got flush=%b halted=%b cnt=%0d state=%0d", o_pipe_flush, o_halted, o_cycle_count, o_state);
    end
    send(C_RUN);
    checks++;
    if (o_state !== 3'd1) begin
      failures++;
      $display("FAIL run_after_flush got state=%0d exp=1", o_state);
    end
    send(C_BREAK);
    finish_drain("break_first_cycle");
    checks++;
    if (o_cycle_count !== CW'(PD) || o_halted !== 1'b1) begin
      failures++;
      $display("FAIL break_first_cycle_cnt got=%0d halted=%b exp=%0d/1", o_cycle_count, o_halted, PD);
    end
  endtask

  task automatic test_step();
    do_flush();
    for (int s = 0; s < 3; s++) begin
      send(C_STEP);
      checks++;
      if ({o_state, o_pipe_en, o_pc_en, o_step_done, o_cmd_ready} !== {3'd2, 4'b1100}) begin
        failures++;
        $display("FAIL step%0d_cycle got state=%0d pe=%b pc=%b sd=%b", s, o_state, o_pipe_en, o_pc_en, o_step_done);
      end
      tick();
      checks++;
      if ({o_state, o_pipe_en, o_step_done} !== {3'd0, 2'b01}) begin
        failures++;
        $display("FAIL step%0d_done got state=%0d pe=%b sd=%b", s, o_state, o_pipe_en, o_step_done);
      end
      tick();
      checks++;
      if (o_step_done !== 1'b0) begin
        failures++;
        $display("FAIL step%0d_pulse_width got sd=%b exp=0", s, o_step_done);
      end
    end
    checks++;
    if (o_cycle_count !== CW'(3) || o_halted !== 1'b0) begin
      failures++;
      $display("FAIL step_count got=%0d halted=%b exp=3/0", o_cycle_count, o_halted);
    end
  endtask

  task automatic test_break();
    do_flush();
    send(C_RUN);
    for (int k = 1; k <= 5; k++) tick();
    send(C_BREAK);
    checks++;
    if (o_state !== 3'd3 || o_cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL break_to_drain got state=%0d rdy=%b exp 3/0", o_state, o_cmd_ready);
    end
    finish_drain("break");
    checks++;
    if (o_cycle_count !== CW'(10) || o_halted !== 1'b1) begin
      failures++;
      $display("FAIL break_count got=%0d halted=%b exp=10/1", o_cycle_count, o_halted);
    end
  endtask

  task automatic test_stall();
    do_flush();
    send(C_RUN);
    tick();
    i_stall_hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({o_state, o_pipe_en, o_pc_en, o_cmd_ready} !== {3'd1, 3'b101}) begin
        failures++;
        $display("FAIL stall%0d got state=%0d pe=%b pc=%b", k, o_state, o_pipe_en, o_pc_en);
      end
      tick();
    end
    i_stall_hazard = 1'b0;
    send(C_STEP);
    checks++;
    if (o_state !== 3'd1 || o_cycle_count !== CW'(4) || o_pc_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_count got state=%0d cnt=%0d pc=%b exp 1/4/1", o_state, o_cycle_count, o_pc_en);
    end
    send(C_BREAK);
    finish_drain("stall_break");
  endtask

  task automatic test_saturate();
    do_flush();
    send(C_RUN);
    repeat (40) tick();
    send(C_BREAK);
    finish_drain("saturate");
    checks++;
    if (o_cycle_count !== CW'(CMAX)) begin
      failures++;
      $display("FAIL saturate got=%0d exp=%0d", o_cycle_count, CMAX);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    send(C_RUN);
    i_halt_fetched = 1'b1;
    tick();
    i_halt_fetched = 1'b0;
    tick();
    #3;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_state !== 3'd0 || o_pipe_en !== 1'b0 || o_cycle_count !== '0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got state=%0d pe=%b cnt=%0d done=%b", o_state, o_pipe_en, o_cycle_count, o_done);
    end
    repeat (PD + 1) begin
      tick();
      checks++;
      if (o_done !== 1'b0 || o_state !== 3'd0) begin
        failures++;
        $display("FAIL async_reset_hold got done=%b state=%0d", o_done, o_state);
      end
    end
    i_rst = 1'b0;
    exp_count = 0;
    exp_halted = 0;
    tick();
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 60; ep++) begin
      int kind = $urandom_range(0, 5);
      if (kind == 0) begin
        do_flush();
      end else if (kind <= 3) begin
        int len = $urandom_range(1, 12);
        bit end_halt = ($urandom_range(0, 2) != 0);
        bit end_break = !end_halt || ($urandom_range(0, 1) == 1);
        send(C_RUN);
        if (exp_halted) begin
          checks++;
          if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin
            failures++;
            $display("FAIL rand%0d run_ignored got state=%0d", ep, o_state);
          end
        end else begin
          for (int k = 1; k <= len; k++) begin
            i_stall_hazard = $urandom_range(0, 1);
            i_halt_fetched = (k == len) && end_halt;
            if (k == len) begin
              i_cmd_valid = end_break;
              i_cmd = C_BREAK;
            end else begin
              i_cmd_valid = ($urandom_range(0, 3) == 0);
              i_cmd = 2'($urandom_range(1, 3));
            end
            #1;
            checks++;
            if ({o_state, o_pipe_en, o_pc_en} !== {3'd1, 1'b1, ~i_stall_hazard & ~i_halt_fetched}) begin
              failures++;
              $display("FAIL rand%0d run_k%0d got state=%0d pc=%b", ep, k, o_state, o_pc_en);
            end
            tick();
          end
          i_cmd_valid = 1'b0;
          i_stall_hazard = 1'b0;
          finish_drain("rand_run");
          i_halt_fetched = 1'b0;
          exp_count = exp_count + len + PD - 1;
          exp_halted = 1;
        end
      end else begin
        bit h = ($urandom_range(0, 3) == 0);
        bit st = $urandom_range(0, 1);
        send(C_STEP);
        if (exp_halted) begin
          checks++;
          if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin
            failures++;
            $display("FAIL rand%0d step_ignored got state=%0d", ep, o_state);
          end
        end else begin
          i_halt_fetched = h;
          i_stall_hazard = st;
          #1;
          checks++;
          if ({o_state, o_pipe_en, o_pc_en} !== {3'd2, 1'b1, ~st & ~h}) begin
            failures++;
            $display("FAIL rand%0d step got state=%0d pc=%b", ep, o_state, o_pc_en);
          end
          tick();
          i_halt_fetched = 1'b0;
          i_stall_hazard = 1'b0;
          checks++;
          if (o_step_done !== 1'b1 || o_state !== (h ? 3'd3 : 3'd0)) begin
            failures++;
            $display("FAIL rand%0d step_done got sd=%b state=%0d", ep, o_step_done, o_state);
          end
          if (h) begin
            finish_drain("rand_step");
            exp_count = exp_count + PD;
            exp_halted = 1;
          end else begin
            exp_count = exp_count + 1;
          end
        end
      end
      if (exp_count > CMAX) exp_count = CMAX;
      checks++;
      if (o_cycle_count !== CW'(exp_count) || o_halted !== exp_halted || o_state !== 3'd0) begin
        failures++;
        $display("FAIL rand%0d end got cnt=%0d halted=%b state=%0d exp cnt=%0d halted=%b state=0",
                 ep, o_cycle_count, o_halted, o_state, exp_count, exp_halted);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_halted_ignore_flush();
    test_step();
    test_break();
    test_stall();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
